// File: rtl/ll_fifo_drain.sv
// Round-robin dequeue scheduler for the shared linked-list FIFO.
// Pops one eligible queue per cycle into a 2-entry valid/ready output buffer.
module ll_fifo_drain #(
  parameter int WIDTH     = 4,
  parameter int NUM_FIFOS = 2,
  parameter int SEL_WIDTH = $clog2(NUM_FIFOS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_FIFOS-1:0] empty,
  input  logic [WIDTH-1:0]     data_out,
  input  logic [NUM_FIFOS-1:0] pop_mask,
  output logic                 pop,
  output logic [SEL_WIDTH-1:0] pop_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_WIDTH-1:0] out_sel,
  output logic [15:0]          drained
);

  logic [NUM_FIFOS-1:0]   elig_s;
  logic [2*NUM_FIFOS-1:0] dbl_s;
  logic [NUM_FIFOS-1:0]   rot_s;
  logic                   found_s;
  logic [SEL_WIDTH-1:0]   grant_off_s;
  logic [SEL_WIDTH:0]     grant_sum_s;
  logic [SEL_WIDTH-1:0]   grant_s;
  logic                   pop_s;
  logic                   deq_s;

  logic [SEL_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [SEL_WIDTH-1:0]   last_sel_q, last_sel_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic                   wr_ptr_q, wr_ptr_d;
  logic [1:0]             occ_q, occ_d;
  logic [15:0]            drained_q, drained_d;
  logic [WIDTH-1:0]       buf_data_q [2];
  logic [WIDTH-1:0]       buf_data_d [2];
  logic [SEL_WIDTH-1:0]   buf_sel_q [2];
  logic [SEL_WIDTH-1:0]   buf_sel_d [2];

  // Rotate eligibility so bit 0 is rr_ptr, find the first set bit, then rotate back.
  always_comb begin
    elig_s      = ~empty & ~pop_mask;
    dbl_s       = {elig_s, elig_s} >> rr_ptr_q;
    rot_s       = dbl_s[NUM_FIFOS-1:0];
    grant_off_s = '0;
    found_s     = 1'b0;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      if (!found_s && rot_s[i]) begin
        grant_off_s = SEL_WIDTH'(i);
        found_s     = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    grant_sum_s = {1'b0, rr_ptr_q} + {1'b0, grant_off_s};
    if (grant_sum_s >= (SEL_WIDTH+1)'(NUM_FIFOS)) begin
      grant_sum_s = grant_sum_s - (SEL_WIDTH+1)'(NUM_FIFOS);
    end else begin
      grant_sum_s = grant_sum_s;
    end
    grant_s = grant_sum_s[SEL_WIDTH-1:0];
  end

  // Pop issue looks only at registered occupancy, never at out_ready.
  always_comb begin
    pop_s      = rst & found_s & (occ_q != 2'd2);
    deq_s      = (occ_q != 2'd0) & out_ready;
    last_sel_d = pop_s ? grant_s : last_sel_q;
    if (pop_s) begin
      rr_ptr_d = (grant_s == SEL_WIDTH'(NUM_FIFOS-1)) ? '0 : grant_s + {{(SEL_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Output buffer write/read pointers, occupancy and the pop counter.
  always_comb begin
    buf_data_d = buf_data_q;
    buf_sel_d  = buf_sel_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    drained_d  = drained_q;
    if (pop_s) begin
      buf_data_d[wr_ptr_q] = data_out;
      buf_sel_d[wr_ptr_q]  = grant_s;
      wr_ptr_d             = ~wr_ptr_q;
      drained_d            = (drained_q == 16'hFFFF) ? drained_q : drained_q + 16'd1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (deq_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({pop_s, deq_s})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // State registers; reset also clears buffer storage so outputs read 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q   <= '0;
      last_sel_q <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      drained_q  <= 16'd0;
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_sel_q[i]  <= '0;
      end
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      last_sel_q <= last_sel_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      occ_q      <= occ_d;
      drained_q  <= drained_d;
      buf_data_q <= buf_data_d;
      buf_sel_q  <= buf_sel_d;
    end
  end

  assign pop       = pop_s;
  assign pop_sel   = last_sel_d;
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = buf_data_q[rd_ptr_q];
  assign out_sel   = buf_sel_q[rd_ptr_q];
  assign drained   = drained_q;

endmodule

// File: tb/tb_ll_fifo_drain.sv
// Self-checking bench for ll_fifo_drain: scenario tasks plus a randomized run
// against a queue-based reference model of the upstream FIFO and output buffer.
module tb_ll_fifo_drain;
  localparam int W  = 4;
  localparam int N  = 2;
  localparam int SW = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  empty = '1;
  logic [W-1:0]  data_out = '0;
  logic [N-1:0]  pop_mask = '0;
  logic          out_ready = 1'b0;
  logic          pop;
  logic [SW-1:0] pop_sel;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [SW-1:0] out_sel;
  logic [15:0]   drained;

  int checks = 0;
  int errors = 0;

  // reference model: upstream queues, output buffer, pointer, counter
  logic [W-1:0]    mq [N][$];
  logic [SW+W-1:0] mbuf [$];
  int m_rr, m_last, m_drained;

  logic            exp_pop, exp_valid;
  logic [SW-1:0]   exp_sel;
  logic [SW+W-1:0] exp_item;
  logic [15:0]     exp_drained;
  logic            obs_pop, obs_valid, obs_pop_empty;
  logic [SW-1:0]   obs_sel, obs_osel;
  logic [W-1:0]    obs_data;
  logic [15:0]     obs_drained;

  ll_fifo_drain #(.WIDTH(W), .NUM_FIFOS(N)) dut (
    .clk(clk), .rst(rst), .empty(empty), .data_out(data_out), .pop_mask(pop_mask),
    .pop(pop), .pop_sel(pop_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel), .drained(drained)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mbuf.delete();
    m_rr = 0;
    m_last = 0;
    m_drained = 0;
  endtask

  // One cycle: present inputs at negedge, sample, feed head word, clock, update model.
  task automatic step();
    logic [N-1:0] elig;
    int g;
    for (int i = 0; i < N; i++) empty[i] = (mq[i].size() == 0);
    #1;
    elig = ~empty & ~pop_mask;
    g = -1;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && elig[(m_rr + k) % N]) g = (m_rr + k) % N;
    end
    exp_pop = rst && (elig != 0) && (mbuf.size() < 2);
    if (exp_pop) m_last = g;
    exp_sel     = SW'(m_last);
    exp_valid   = (mbuf.size() != 0);
    exp_item    = exp_valid ? mbuf[0] : '0;
    exp_drained = 16'(m_drained);
    obs_pop = pop; obs_sel = pop_sel; obs_valid = out_valid;
    obs_data = out_data; obs_osel = out_sel; obs_drained = drained;
    obs_pop_empty = pop && empty[pop_sel];
    if (pop && !empty[pop_sel]) data_out = mq[pop_sel][0];
    else data_out = W'($urandom);
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      if (exp_valid && out_ready) void'(mbuf.pop_front());
      if (exp_pop) begin
        mbuf.push_back({SW'(g), mq[g][0]});
        void'(mq[g].pop_front());
        m_rr = (g + 1) % N;
        if (m_drained < 65535) m_drained++;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < N; i++) mq[i].delete();
    model_reset();
    pop_mask = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < N; i++) mq[i].delete();
    model_reset();
    for (int c = 0; c < 5; c++) begin
      if (c == 3) rst = 1'b1;
      step();
      checks++;
      if (obs_pop !== 1'b0 || obs_valid !== 1'b0 || obs_drained !== 16'd0) begin
        errors++;
        $display("FAIL reset_c%0d got pop=%0b valid=%0b drained=%0d want 0 0 0", c, obs_pop, obs_valid, obs_drained);
      end
      checks++;
      if (obs_data !== 4'd0 || obs_sel !== 1'b0 || obs_osel !== 1'b0) begin
        errors++;
        $display("FAIL reset_zero_c%0d got data=%0h sel=%0d osel=%0d want 0", c, obs_data, obs_sel, obs_osel);
      end
    end
  endtask

  task automatic test_fairness();
    do_reset();
    for (int i = 0; i < N; i++) repeat (3) mq[i].push_back(W'($urandom));
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      if (c < 4) begin
        checks++;
        if (obs_pop !== 1'b1 || obs_sel !== SW'(c % 2)) begin
          errors++;
          $display("FAIL rr_pop%0d got pop=%0b sel=%0d want 1 %0d", c, obs_pop, obs_sel, c % 2);
        end
      end
      if (c > 0) begin
        checks++;
        if (obs_valid !== 1'b1 || obs_osel !== SW'((c - 1) % 2) || obs_data !== exp_item[W-1:0]) begin
          errors++;
          $display("FAIL rr_out%0d got v=%0b sel=%0d d=%0h want 1 %0d %0h", c, obs_valid, obs_osel, obs_data, (c - 1) % 2, exp_item[W-1:0]);
        end
      end
    end
    checks++;
    if (obs_drained !== 16'd4) begin
      errors++;
      $display("FAIL rr_drained got %0d want 4", obs_drained);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] wa, wb, wc;
    do_reset();
    wa = W'($urandom); wb = W'($urandom); wc = W'($urandom);
    mq[0].push_back(wa); mq[0].push_back(wb); mq[0].push_back(wc);
    out_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      out_ready = (c == 4);
      step();
      checks++;
      if (obs_pop !== ((c < 2 || c == 5) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL bp_pop%0d got %0b want %0b", c, obs_pop, (c < 2 || c == 5));
      end
      if (c >= 1) begin
        checks++;
        if (obs_valid !== 1'b1 || obs_data !== ((c <= 4) ? wa : wb)) begin
          errors++;
          $display("FAIL bp_data%0d got v=%0b d=%0h want 1 %0h", c, obs_valid, obs_data, (c <= 4) ? wa : wb);
        end
      end
    end
    checks++;
    if (obs_drained !== 16'd3 || mq[0].size() != 0) begin
      errors++;
      $display("FAIL bp_count got drained=%0d left=%0d want 3 0", obs_drained, mq[0].size());
    end
  endtask

  task automatic test_mask_wrap();
    do_reset();
    for (int i = 0; i < N; i++) repeat (3) mq[i].push_back(W'($urandom));
    out_ready = 1'b1;
    pop_mask = 2'b10;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) pop_mask = 2'b00;
      step();
      checks++;
      if (obs_pop !== 1'b1 || obs_sel !== SW'(c == 2 ? 1 : 0)) begin
        errors++;
        $display("FAIL mask%0d got pop=%0b sel=%0d want 1 %0d", c, obs_pop, obs_sel, (c == 2) ? 1 : 0);
      end
    end
  endtask

  task automatic test_emptying();
    logic [W-1:0] w;
    do_reset();
    w = W'($urandom);
    mq[1].push_back(w);
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (obs_pop !== (c == 0) || obs_pop_empty !== 1'b0 || (c == 0 && obs_sel !== 1'b1)) begin
        errors++;
        $display("FAIL empty%0d got pop=%0b sel=%0d popempty=%0b want %0b 1 0", c, obs_pop, obs_sel, obs_pop_empty, c == 0);
      end
    end
    checks++;
    if (obs_drained !== 16'd1) begin
      errors++;
      $display("FAIL empty_drained got %0d want 1", obs_drained);
    end
  endtask

  task automatic test_midstream_reset();
    do_reset();
    for (int i = 0; i < N; i++) repeat (3) mq[i].push_back(W'($urandom));
    out_ready = 1'b0;
    pop_mask = 2'b10;
    repeat (3) step();
    checks++;
    if (obs_valid !== 1'b1 || obs_pop !== 1'b0) begin
      errors++;
      $display("FAIL mid_full got v=%0b pop=%0b want 1 0", obs_valid, obs_pop);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 4'd0 || pop !== 1'b0) begin
      errors++;
      $display("FAIL mid_async got v=%0b d=%0h pop=%0b want 0 0 0", out_valid, out_data, pop);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    pop_mask = 2'b00;
    step();
    checks++;
    if (obs_valid !== 1'b0 || obs_pop !== 1'b1 || obs_sel !== 1'b0 || obs_drained !== 16'd0) begin
      errors++;
      $display("FAIL mid_release got v=%0b pop=%0b sel=%0d dr=%0d want 0 1 0 0", obs_valid, obs_pop, obs_sel, obs_drained);
    end
    step();
    checks++;
    if (obs_valid !== 1'b1 || obs_sel !== 1'b1 || obs_drained !== 16'd1) begin
      errors++;
      $display("FAIL mid_next got v=%0b sel=%0d dr=%0d want 1 1 1", obs_valid, obs_sel, obs_drained);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) != 0) begin
        int q = $urandom_range(0, N - 1);
        if (mq[q].size() < 6) mq[q].push_back(W'($urandom));
      end
      pop_mask  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      out_ready = ($urandom_range(0, 3) != 0);
      step();
      checks++;
      if (obs_pop !== exp_pop || obs_sel !== exp_sel || obs_pop_empty !== 1'b0) begin
        errors++;
        $display("FAIL rnd_pop%0d got pop=%0b sel=%0d want %0b %0d", c, obs_pop, obs_sel, exp_pop, exp_sel);
      end
      checks++;
      if (obs_valid !== exp_valid || (exp_valid && {obs_osel, obs_data} !== exp_item)) begin
        errors++;
        $display("FAIL rnd_out%0d got v=%0b item=%0h want %0b %0h", c, obs_valid, {obs_osel, obs_data}, exp_valid, exp_item);
      end
      checks++;
      if (obs_drained !== exp_drained) begin
        errors++;
        $display("FAIL rnd_drained%0d got %0d want %0d", c, obs_drained, exp_drained);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fairness();
    test_backpressure();
    test_mask_wrap();
    test_emptying();
    test_midstream_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
